// File: rtl/mul_arbiter_mul.sv
// Full-precision signed multiplier shared by the arbitrated requesters.
// Purely combinational; the caller registers both operands and product.
module mul_arbiter_mul #(
   parameter int WIDTH_A = 8,
   parameter int WIDTH_B = 8,
   parameter int WIDTH_P = WIDTH_A + WIDTH_B
) (
   input  logic signed [WIDTH_A-1:0] a,
   input  logic signed [WIDTH_B-1:0] b,
   output logic signed [WIDTH_P-1:0] p
);

   // Sign-extend both operands to the product width so the multiply cannot overflow.
   assign p = WIDTH_P'(a) * WIDTH_P'(b);

endmodule

// File: rtl/mul_arbiter.sv
// Round-robin arbiter feeding NUM_REQ requesters into one signed multiplier.
// Two-stage pipeline: S1 holds the granted operands, S2 holds the product.
module mul_arbiter #(
   parameter int NUM_REQ          = 4,
   parameter int WIDTH_MUL_INPUT1 = 8,
   parameter int WIDTH_MUL_INPUT2 = 8,
   parameter int WIDTH_MUL        = WIDTH_MUL_INPUT1 + WIDTH_MUL_INPUT2,
   localparam int ID_W            = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic [NUM_REQ-1:0]                    req_valid,
   output logic [NUM_REQ-1:0]                    req_ready,
   input  logic [NUM_REQ*WIDTH_MUL_INPUT1-1:0]   req_a,
   input  logic [NUM_REQ*WIDTH_MUL_INPUT2-1:0]   req_b,
   output logic                                  res_valid,
   input  logic                                  res_ready,
   output logic signed [WIDTH_MUL-1:0]           res_data,
   output logic [ID_W-1:0]                       res_id
);

   logic signed [WIDTH_MUL_INPUT1-1:0] a_arr [NUM_REQ];
   logic signed [WIDTH_MUL_INPUT2-1:0] b_arr [NUM_REQ];

   logic                               s1_vld_q, s1_vld_d;
   logic signed [WIDTH_MUL_INPUT1-1:0] s1_a_q, s1_a_d;
   logic signed [WIDTH_MUL_INPUT2-1:0] s1_b_q, s1_b_d;
   logic [ID_W-1:0]                    s1_id_q, s1_id_d;
   logic                               s2_vld_q, s2_vld_d;
   logic signed [WIDTH_MUL-1:0]        s2_data_q, s2_data_d;
   logic [ID_W-1:0]                    s2_id_q, s2_id_d;
   logic [ID_W-1:0]                    rr_ptr_q, rr_ptr_d;

   logic                               s1_en, s2_en;
   logic                               gnt_found, accept;
   logic [ID_W-1:0]                    gnt_idx, idx;
   logic signed [WIDTH_MUL-1:0]        prod;

   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         a_arr[i] = req_a[i*WIDTH_MUL_INPUT1 +: WIDTH_MUL_INPUT1];
         b_arr[i] = req_b[i*WIDTH_MUL_INPUT2 +: WIDTH_MUL_INPUT2];
      end
   end

   // Round-robin search: first valid requester at or after rr_ptr, wrapping.
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      idx       = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = ID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
         if (!gnt_found && req_valid[idx]) begin
            gnt_found = 1'b1;
            gnt_idx   = idx;
         end
      end
   end

   assign s2_en  = !s2_vld_q || res_ready;
   assign s1_en  = !s1_vld_q || s2_en;
   assign accept = gnt_found && s1_en && !rst;

   mul_arbiter_mul #(
      .WIDTH_A (WIDTH_MUL_INPUT1),
      .WIDTH_B (WIDTH_MUL_INPUT2),
      .WIDTH_P (WIDTH_MUL)
   ) u_mul (
      .a (s1_a_q),
      .b (s1_b_q),
      .p (prod)
   );

   always_comb begin
      req_ready = '0;
      s1_vld_d  = s1_vld_q;
      s1_a_d    = s1_a_q;
      s1_b_d    = s1_b_q;
      s1_id_d   = s1_id_q;
      s2_vld_d  = s2_vld_q;
      s2_data_d = s2_data_q;
      s2_id_d   = s2_id_q;
      rr_ptr_d  = rr_ptr_q;
      if (accept) begin
         req_ready[gnt_idx] = 1'b1;
         s1_a_d             = a_arr[gnt_idx];
         s1_b_d             = b_arr[gnt_idx];
         s1_id_d            = gnt_idx;
         rr_ptr_d           = ID_W'((int'(gnt_idx) + 1) % NUM_REQ);
      end
      if (s1_en) s1_vld_d = accept;
      // Product and id only move when S1 really holds an operation, so S2 stays stable otherwise.
      if (s2_en) begin
         s2_vld_d = s1_vld_q;
         if (s1_vld_q) begin
            s2_data_d = prod;
            s2_id_d   = s1_id_q;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_vld_q  <= 1'b0;
         s1_a_q    <= '0;
         s1_b_q    <= '0;
         s1_id_q   <= '0;
         s2_vld_q  <= 1'b0;
         s2_data_q <= '0;
         s2_id_q   <= '0;
         rr_ptr_q  <= '0;
      end else begin
         s1_vld_q  <= s1_vld_d;
         s1_a_q    <= s1_a_d;
         s1_b_q    <= s1_b_d;
         s1_id_q   <= s1_id_d;
         s2_vld_q  <= s2_vld_d;
         s2_data_q <= s2_data_d;
         s2_id_q   <= s2_id_d;
         rr_ptr_q  <= rr_ptr_d;
      end
   end

   assign res_valid = s2_vld_q;
   assign res_data  = s2_data_q;
   assign res_id    = s2_id_q;

endmodule
